// File: rtl/ara_ctrl_regs_pkg.sv
// Shared types for the end-of-computation / debug control register responder.
// Holds the register index map, VCD trigger encodings and the response record.
package ara_ctrl_regs_pkg;

  typedef enum logic [2:0] {
    RegExit         = 3'd0,
    RegEventTrigger = 3'd1,
    RegHwCntEn      = 3'd2,
    RegRuntime      = 3'd3,
    RegRuntimeBuf   = 3'd4
  } reg_idx_e;

  typedef enum logic {
    StIdle = 1'b0,
    StResp = 1'b1
  } state_e;

  localparam logic [63:0] VcdTriggerOn  = 64'h1;
  localparam logic [63:0] VcdTriggerOff = '1;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/ara_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes the saturated
// next value so a caller can capture the count including the current cycle.
module ara_sat_counter #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] q_inc_o
);

  logic [Width-1:0] cnt_q;

  function automatic logic [Width-1:0] sat_inc(input logic [Width-1:0] v);
    return (&v) ? v : v + Width'(1);
  endfunction

  assign q_inc_o = sat_inc(cnt_q);
  assign q_o     = cnt_q;

  // clear wins over increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= q_inc_o;
    end
  end

endmodule

// File: rtl/ara_exit_ctrl_regs.sv
// Peripheral register responder for exit/tohost, VCD event trigger, HW counter
// enables and a runtime cycle counter gated by counter-enable bit 0.
module ara_exit_ctrl_regs
  import ara_ctrl_regs_pkg::*;
#(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned NrCounters = 8,
  parameter int unsigned CntWidth   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AddrWidth-1:0]  req_addr_i,
  input  logic                  req_we_i,
  input  logic [63:0]           req_wdata_i,
  input  logic [7:0]            req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [63:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [63:0]           exit_o,
  output logic [63:0]           event_trigger_o,
  output logic [NrCounters-1:0] hw_cnt_en_o,
  output logic [CntWidth-1:0]   runtime_buf_o
);

  state_e                state_q, state_d;
  rsp_t                  rsp_q, rsp_d;
  logic [63:0]           exit_q, event_q;
  logic [NrCounters-1:0] hw_cnt_en_q, hw_new;
  logic [CntWidth-1:0]   runtime_buf_q, cnt_q, cnt_inc;
  logic [63:0]           cur_val, merged;
  logic                  mapped, writable, accept, do_write;
  logic                  wr_exit, wr_evt, wr_hw, cnt_clr, cnt_latch;
  reg_idx_e              idx;
  logic                  unused_addr;

  function automatic logic [63:0] be_merge(input logic [63:0] old_v,
                                           input logic [63:0] new_v,
                                           input logic [7:0]  be);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  assign unused_addr = ^{req_addr_i[AddrWidth-1:6], req_addr_i[2:0]};
  assign idx         = reg_idx_e'(req_addr_i[5:3]);

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = StResp;
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept = req_valid_i && (state_q == StIdle);

  // Address decode: current register value and access permissions
  always_comb begin
    cur_val  = '0;
    mapped   = 1'b1;
    writable = 1'b1;
    case (idx)
      RegExit:         cur_val = exit_q;
      RegEventTrigger: cur_val = event_q;
      RegHwCntEn:      cur_val = 64'(hw_cnt_en_q);
      RegRuntime: begin
        cur_val  = 64'(cnt_q);
        writable = 1'b0;
      end
      RegRuntimeBuf: begin
        cur_val  = 64'(runtime_buf_q);
        writable = 1'b0;
      end
      default: begin
        mapped   = 1'b0;
        writable = 1'b0;
      end
    endcase
  end

  always_comb begin
    rsp_d.err   = !mapped || (req_we_i && !writable);
    rsp_d.rdata = (!req_we_i && mapped) ? cur_val : '0;
  end

  assign merged   = be_merge(cur_val, req_wdata_i, req_be_i);
  assign hw_new   = merged[NrCounters-1:0];
  assign do_write = accept && req_we_i && !rsp_d.err;
  // a done exit word is sticky until reset; the write is silently dropped
  assign wr_exit  = do_write && (idx == RegExit) && !exit_q[0];
  assign wr_evt   = do_write && (idx == RegEventTrigger);
  assign wr_hw    = do_write && (idx == RegHwCntEn);

  assign cnt_clr   = wr_hw && !hw_cnt_en_q[0] && hw_new[0];
  assign cnt_latch = wr_hw && hw_cnt_en_q[0] && !hw_new[0];

  ara_sat_counter #(
    .Width (CntWidth)
  ) i_runtime_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (hw_cnt_en_q[0]),
    .clr_i   (cnt_clr),
    .q_o     (cnt_q),
    .q_inc_o (cnt_inc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      rsp_q         <= '0;
      exit_q        <= '0;
      event_q       <= '0;
      hw_cnt_en_q   <= '0;
      runtime_buf_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) rsp_q <= rsp_d;
      if (wr_exit) exit_q <= merged;
      if (wr_evt) event_q <= merged;
      if (wr_hw) hw_cnt_en_q <= hw_new;
      // latched value includes the final enabled cycle
      if (cnt_latch) runtime_buf_q <= cnt_inc;
    end
  end

  assign rsp_rdata_o     = rsp_q.rdata;
  assign rsp_err_o       = rsp_q.err;
  assign exit_o          = exit_q;
  assign event_trigger_o = event_q;
  assign hw_cnt_en_o     = hw_cnt_en_q;
  assign runtime_buf_o   = runtime_buf_q;

endmodule

// File: tb/tb_ara_exit_ctrl_regs.sv
// Directed bench for ara_exit_ctrl_regs: a default 64-bit-counter instance and a
// 4-bit-counter instance share one request bus.
module tb_ara_exit_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_we;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        rsp_ready;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [63:0] a_rsp_rdata, a_exit, a_evt, a_rtbuf;
  logic [7:0]  a_hw;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [63:0] b_rsp_rdata, b_exit, b_evt;
  logic [3:0]  b_rtbuf;
  logic [7:0]  b_hw;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ara_exit_ctrl_regs dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(a_req_ready),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(a_rsp_rdata),
    .rsp_err_o(a_rsp_err), .exit_o(a_exit), .event_trigger_o(a_evt), .hw_cnt_en_o(a_hw),
    .runtime_buf_o(a_rtbuf)
  );

  ara_exit_ctrl_regs #(.CntWidth(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(b_req_ready),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(b_rsp_rdata),
    .rsp_err_o(b_rsp_err), .exit_o(b_exit), .event_trigger_o(b_evt), .hw_cnt_en_o(b_hw),
    .runtime_buf_o(b_rtbuf)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // One request with an immediately ready response; returns at the negedge
  // where the response is visible, accept-edge cycle number in acc.
  task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] be, output logic [63:0] rd_a, output logic er_a,
                      output logic [63:0] rd_b, output logic er_b, output int acc);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsp_valid", {62'd0, a_rsp_valid, b_rsp_valid}, 64'd3);
    rd_a = a_rsp_rdata; er_a = a_rsp_err;
    rd_b = b_rsp_rdata; er_b = b_rsp_err;
  endtask

  logic [63:0] rd_a, rd_b, ref_rd;
  logic        er_a, er_b, stable;
  int          acc, t_en, t_dis;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_exit", a_exit, 64'd0);
    chk("reset_evt", a_evt, 64'd0);
    chk("reset_hw", {56'd0, a_hw}, 64'd0);
    chk("reset_rtbuf", a_rtbuf, 64'd0);
    chk("reset_ready", {63'd0, a_req_ready}, 64'd1);
    chk("reset_rsp_valid", {63'd0, a_rsp_valid}, 64'd0);

    vq.push_back('{1'b0, 64'h00, 64'h0, 8'h00, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h08, 64'h0, 8'h00, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h10, 64'h0, 8'h00, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h18, 64'h0, 8'h00, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h20, 64'h0, 8'h00, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h28, 64'h0, 8'h00, 64'h0, 1'b1});
    vq.push_back('{1'b0, 64'h38, 64'h0, 8'h00, 64'h0, 1'b1});
    vq.push_back('{1'b1, 64'h18, 64'hFFFF, 8'hFF, 64'h0, 1'b1});
    vq.push_back('{1'b1, 64'h30, 64'h1, 8'hFF, 64'h0, 1'b1});
    vq.push_back('{1'b1, 64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h0C, 64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF, 1'b0});
    vq.push_back('{1'b1, 64'h10, 64'h1234, 8'h01, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h10, 64'h0, 8'h00, 64'h34, 1'b0});
    vq.push_back('{1'b1, 64'h10, 64'hFF00, 8'h02, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h10, 64'h0, 8'h00, 64'h34, 1'b0});
    vq.push_back('{1'b1, 64'h00, 64'h3, 8'hFF, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h00, 64'h0, 8'h00, 64'h3, 1'b0});
    vq.push_back('{1'b1, 64'h00, 64'h5, 8'hFF, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h00, 64'h0, 8'h00, 64'h3, 1'b0});
    vq.push_back('{1'b1, 64'h10, 64'h0, 8'hFF, 64'h0, 1'b0});
    vq.push_back('{1'b0, 64'h10, 64'h0, 8'h00, 64'h0, 1'b0});

    foreach (vq[i]) begin
      xact(vq[i].we, vq[i].addr, vq[i].wdata, vq[i].be, rd_a, er_a, rd_b, er_b, acc);
      chk($sformatf("vec%0d_rdata", i), rd_a, vq[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {63'd0, er_a}, {63'd0, vq[i].exp_err});
      chk($sformatf("vec%0d_rdata_w4", i), rd_b, vq[i].exp_rdata);
      chk($sformatf("vec%0d_err_w4", i), {63'd0, er_b}, {63'd0, vq[i].exp_err});
    end
    chk("exit_sticky", a_exit, 64'h3);
    chk("evt_partial_be", a_evt, 64'h0000_0000_FFFF_FFFF);
    chk("hw_cleared", {56'd0, a_hw}, 64'd0);

    // runtime measurement across an enable / disable pair
    xact(1'b1, 64'h10, 64'h1, 8'h01, rd_a, er_a, rd_b, er_b, t_en);
    chk("hw_enabled", {56'd0, a_hw}, 64'h1);
    repeat (100) @(negedge clk);
    xact(1'b1, 64'h10, 64'h0, 8'h01, rd_a, er_a, rd_b, er_b, t_dis);
    chk("runtime_buf", a_rtbuf, 64'(t_dis - t_en));
    chk("runtime_buf_w4_sat", {60'd0, b_rtbuf}, 64'hF);
    xact(1'b0, 64'h20, 64'h0, 8'h00, rd_a, er_a, rd_b, er_b, acc);
    chk("rd_runtime_buf", rd_a, 64'(t_dis - t_en));
    xact(1'b0, 64'h18, 64'h0, 8'h00, rd_a, er_a, rd_b, er_b, acc);
    chk("rd_runtime_frozen", rd_a, 64'(t_dis - t_en));
    chk("rd_runtime_w4", rd_b, 64'hF);

    // response back-pressure: held data, no second accept
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h08; rsp_ready = 1'b0;
    @(negedge clk);
    ref_rd = a_rsp_rdata;
    req_we = 1'b1; req_wdata = 64'h0; req_be = 8'hFF;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!a_rsp_valid || a_rsp_rdata !== ref_rd || a_req_ready) stable = 1'b0;
    end
    chk("hold_stable", {63'd0, stable}, 64'd1);
    chk("hold_rdata", ref_rd, 64'h0000_0000_FFFF_FFFF);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_released", {62'd0, a_rsp_valid, a_req_ready}, 64'd1);
    chk("hold_no_write", a_evt, 64'h0000_0000_FFFF_FFFF);

    // saturation of the narrow counter, then reset during a response
    xact(1'b1, 64'h10, 64'h1, 8'h01, rd_a, er_a, rd_b, er_b, t_en);
    repeat (20) @(negedge clk);
    xact(1'b0, 64'h18, 64'h0, 8'h00, rd_a, er_a, rd_b, er_b, acc);
    chk("runtime_w4_sat", rd_b, 64'hF);
    chk("runtime_w64", rd_a, 64'(acc - t_en - 1));
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h00; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_rsp_valid", {63'd0, a_rsp_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1;
    chk("rst_drops_rsp", {62'd0, a_rsp_valid, b_rsp_valid}, 64'd0);
    chk("rst_exit", a_exit, 64'd0);
    chk("rst_hw", {48'd0, a_hw, b_hw}, 64'd0);
    chk("rst_rtbuf", a_rtbuf, 64'd0);
    xact(1'b0, 64'h18, 64'h0, 8'h00, rd_a, er_a, rd_b, er_b, acc);
    chk("rst_runtime", rd_a, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
